// File: rtl/alu_pkg.sv
// Shared types and default sizes for the ALU result accumulator.
package alu_pkg;

  typedef enum logic {
    LIVE   = 1'b0,
    BROWSE = 1'b1
  } acc_state_t;

  localparam int ALU_W          = 8;
  localparam int ALU_HIST_DEPTH = 4;

endpackage

// File: rtl/key_press_detect.sv
// Two-flop synchroniser plus edge detector for an active-low push button.
// Flops clear to "pressed" so a key held through reset yields no press.
module key_press_detect (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic s1_reg;
  logic s2_reg;
  logic prev_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg   <= 1'b0;
      s2_reg   <= 1'b0;
      prev_reg <= 1'b0;
    end else begin
      s1_reg   <= key_n;
      s2_reg   <= s1_reg;
      prev_reg <= s2_reg;
    end
  end

  // Released-to-pressed transition of the synchronised key.
  assign press = prev_reg & ~s2_reg;

endmodule

// File: rtl/alu_result_accumulator.sv
// Accumulator stage behind the ALU with an optional browsable history ring.
// Define ALU_HIST_EN to build the history ring, recall key and BROWSE state.
module alu_result_accumulator
  import alu_pkg::*;
#(
  parameter int W          = ALU_W,
  parameter int HIST_DEPTH = ALU_HIST_DEPTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [W-1:0]                  alu_result,
  input  logic                          load_key_n,
  input  logic                          recall_key_n,
  output logic [W-1:0]                  acc_out,
  output logic [3:0]                    b_feedback,
  output logic [W-1:0]                  disp_val,
  output logic                          browsing,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
  output logic                          load_pulse
);

  logic         load_press;
  logic [W-1:0] acc_reg;
  logic         load_pulse_reg;

  key_press_detect u_load_key (
    .clk   (clk),
    .reset (reset),
    .key_n (load_key_n),
    .press (load_press)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg        <= '0;
      load_pulse_reg <= 1'b0;
    end else begin
      load_pulse_reg <= load_press;
      if (load_press) begin
        acc_reg <= alu_result;
      end
    end
  end

  assign acc_out    = acc_reg;
  assign b_feedback = acc_reg[3:0];
  assign load_pulse = load_pulse_reg;

`ifdef ALU_HIST_EN
  localparam int PW = $clog2(HIST_DEPTH);
  localparam int CW = PW + 1;

  logic          recall_press;
  logic [W-1:0]  hist_reg [HIST_DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] off_reg;
  logic [CW-1:0] count_reg;
  acc_state_t    state_reg;
  logic [PW-1:0] rd_idx;

  key_press_detect u_recall_key (
    .clk   (clk),
    .reset (reset),
    .key_n (recall_key_n),
    .press (recall_press)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_reg[i] <= '0;
      end
    end else if (load_press) begin
      hist_reg[wr_ptr_reg] <= alu_result;
    end
  end

  // A load always wins over a same-cycle recall press.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      off_reg    <= '0;
      count_reg  <= '0;
      state_reg  <= LIVE;
    end else if (load_press) begin
      wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (count_reg != CW'(HIST_DEPTH)) begin
        count_reg <= count_reg + CW'(1);
      end
      state_reg <= LIVE;
    end else if (recall_press) begin
      case (state_reg)
        LIVE: begin
          if (count_reg != '0) begin
            state_reg <= BROWSE;
            off_reg   <= '0;
          end
        end
        BROWSE: begin
          if (({1'b0, off_reg} + CW'(1)) == count_reg) begin
            state_reg <= LIVE;
          end else begin
            off_reg <= off_reg + PW'(1);
          end
        end
        default: state_reg <= LIVE;
      endcase
    end
  end

  // Newest entry sits just behind the write pointer; wraps naturally in PW bits.
  assign rd_idx     = wr_ptr_reg - PW'(1) - off_reg;
  assign browsing   = (state_reg == BROWSE);
  assign disp_val   = (state_reg == BROWSE) ? hist_reg[rd_idx] : acc_reg;
  assign hist_count = count_reg;
`else
  logic unused_recall_key;

  assign unused_recall_key = recall_key_n;
  assign disp_val          = acc_reg;
  assign browsing          = 1'b0;
  assign hist_count        = '0;
`endif

endmodule

// File: tb/tb_alu_result_accumulator.sv
// Scoreboard bench for alu_result_accumulator; expectations adapt to ALU_HIST_EN.
module tb_alu_result_accumulator;

`ifdef ALU_HIST_EN
  localparam bit HEN = 1'b1;
`else
  localparam bit HEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] alu_result = 8'h00;
  logic       load_key_n = 1'b1;
  logic       recall_key_n = 1'b1;
  logic [7:0] acc_out;
  logic [3:0] b_feedback;
  logic [7:0] disp_val;
  logic       browsing;
  logic [2:0] hist_count;
  logic       load_pulse;

  alu_result_accumulator dut (
    .clk          (clk),
    .reset        (reset),
    .alu_result   (alu_result),
    .load_key_n   (load_key_n),
    .recall_key_n (recall_key_n),
    .acc_out      (acc_out),
    .b_feedback   (b_feedback),
    .disp_val     (disp_val),
    .browsing     (browsing),
    .hist_count   (hist_count),
    .load_pulse   (load_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] acc;
    logic [7:0] disp;
    logic       brw;
    logic [2:0] hc;
  } exp_t;

  exp_t load_q[$];
  exp_t disp_q[$];
  exp_t le;
  exp_t de;
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic exp_t mk(input int due, input logic [7:0] acc, input logic [7:0] disp,
                              input logic brw, input logic [2:0] hc);
    exp_t e;
    e.due = due; e.acc = acc; e.disp = disp; e.brw = brw; e.hc = hc;
    return e;
  endfunction

  function automatic logic [2:0] hc(input int n);
    return HEN ? 3'(n) : 3'd0;
  endfunction

  // Monitor: load_pulse pops the load queue; display checks pop when due.
  always @(negedge clk) begin
    if (load_q.size() > 0 && load_q[0].due < cyc) begin
      le = load_q.pop_front();
      n_vec++; n_bad++;
      $display("FAIL load_missing: no load_pulse by cycle %0d, required at cycle %0d acc %h", cyc, le.due, le.acc);
    end
    if (load_pulse) begin
      n_vec++;
      if (load_q.size() == 0) begin
        n_bad++;
        $display("FAIL load_unexpected: load_pulse at cycle %0d acc_out=%h, required none", cyc, acc_out);
      end else begin
        le = load_q.pop_front();
        if (cyc != le.due || acc_out !== le.acc || b_feedback !== le.acc[3:0] || hist_count !== le.hc) begin
          n_bad++;
          $display("FAIL load: cyc=%0d acc=%h b=%h hc=%0d, required cyc=%0d acc=%h b=%h hc=%0d",
                   cyc, acc_out, b_feedback, hist_count, le.due, le.acc, le.acc[3:0], le.hc);
        end else begin
          $display("load   cyc=%0d acc=%h b=%h hc=%0d ok", cyc, acc_out, b_feedback, hist_count);
        end
      end
    end
    while (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
      de = disp_q.pop_front();
      n_vec++;
      if (acc_out !== de.acc || b_feedback !== de.acc[3:0] || disp_val !== de.disp ||
          browsing !== de.brw || hist_count !== de.hc) begin
        n_bad++;
        $display("FAIL disp: cyc=%0d acc=%h disp=%h brw=%b hc=%0d, required acc=%h disp=%h brw=%b hc=%0d",
                 cyc, acc_out, disp_val, browsing, hist_count, de.acc, de.disp, de.brw, de.hc);
      end else begin
        $display("disp   cyc=%0d acc=%h disp=%h brw=%b hc=%0d ok", cyc, acc_out, disp_val, browsing, hist_count);
      end
    end
  end

  task automatic start_press(input bit ld, input bit rc, output int k);
    @(posedge clk); #1;
    k = cyc;
    if (ld) load_key_n = 1'b0;
    if (rc) recall_key_n = 1'b0;
  endtask

  task automatic finish_press(input int hold);
    repeat (hold) @(posedge clk);
    #1;
    load_key_n   = 1'b1;
    recall_key_n = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic do_load(input logic [7:0] v, input logic [2:0] h);
    int k;
    alu_result = v;
    start_press(1'b1, 1'b0, k);
    load_q.push_back(mk(k + 3, v, v, 1'b0, h));
    disp_q.push_back(mk(k + 3, v, v, 1'b0, h));
    finish_press(6);
  endtask

  task automatic do_recall(input logic [7:0] acc, input logic [7:0] disp, input logic brw,
                           input logic [2:0] h);
    int k;
    start_press(1'b0, 1'b1, k);
    disp_q.push_back(mk(k + 3, acc, disp, brw, h));
    finish_press(2);
  endtask

  initial begin
    int k;
    // Reset with keys released
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    disp_q.push_back(mk(cyc, 8'h00, 8'h00, 1'b0, 3'd0));
    disp_q.push_back(mk(cyc + 9, 8'h00, 8'h00, 1'b0, 3'd0));
    repeat (10) @(posedge clk);

    // Recall with empty history is ignored
    do_recall(8'h00, 8'h00, 1'b0, 3'd0);

    // Single load
    do_load(8'h2A, hc(1));

    // Fill and wrap the ring
    do_load(8'h01, hc(2));
    do_load(8'h02, hc(3));
    do_load(8'h03, hc(4));
    do_load(8'h04, hc(4));
    do_load(8'h05, hc(4));

    // Browse newest to oldest, then back to LIVE
    do_recall(8'h05, 8'h05, HEN, hc(4));
    do_recall(8'h05, HEN ? 8'h04 : 8'h05, HEN, hc(4));
    do_recall(8'h05, HEN ? 8'h03 : 8'h05, HEN, hc(4));
    do_recall(8'h05, HEN ? 8'h02 : 8'h05, HEN, hc(4));
    do_recall(8'h05, 8'h05, 1'b0, hc(4));

    // Enter BROWSE, then load and recall in the same cycle
    do_recall(8'h05, 8'h05, HEN, hc(4));
    alu_result = 8'h77;
    start_press(1'b1, 1'b1, k);
    load_q.push_back(mk(k + 3, 8'h77, 8'h77, 1'b0, hc(4)));
    disp_q.push_back(mk(k + 3, 8'h77, 8'h77, 1'b0, hc(4)));
    finish_press(3);
    do_recall(8'h77, 8'h77, HEN, hc(4));
    do_recall(8'h77, HEN ? 8'h05 : 8'h77, HEN, hc(4));

    // Reset while browsing with the load key held down
    @(posedge clk); #1;
    reset      = 1'b1;
    load_key_n = 1'b0;
    alu_result = 8'h99;
    disp_q.push_back(mk(cyc + 1, 8'h00, 8'h00, 1'b0, 3'd0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    disp_q.push_back(mk(cyc + 6, 8'h00, 8'h00, 1'b0, 3'd0));
    repeat (8) @(posedge clk);
    #1 load_key_n = 1'b1;
    repeat (4) @(posedge clk);

    // Fresh press after release, then a one-entry browse round trip
    do_load(8'h3C, hc(1));
    do_recall(8'h3C, 8'h3C, HEN, hc(1));
    do_recall(8'h3C, 8'h3C, 1'b0, hc(1));

    repeat (6) @(posedge clk);
    #1;
    n_vec++;
    if (load_q.size() != 0 || disp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending load=%0d disp=%0d, required 0 and 0", load_q.size(), disp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
